// File: rtl/secuenciador_alu.sv
// rtl/secuenciador_alu.sv - command sequencer driving an 8-bit ALU for 8/16-bit operations
module secuenciador_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_ancho,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  input  logic [7:0]  alu_resultado,
  input  logic [3:0]  alu_banderas,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_dato,
  output logic [3:0]  res_banderas,
  output logic        ocupado
);

  typedef enum logic [1:0] {IDLE, BAJO, ALTO, HECHO} estado_t;

  // Flag nibble bit positions
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  estado_t     estado_q, estado_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        ancho_q, ancho_d;
  logic [7:0]  dato_bajo_q, dato_bajo_d;
  logic [3:0]  flags_bajo_q, flags_bajo_d;
  logic [15:0] res_dato_q, res_dato_d;
  logic [3:0]  res_banderas_q, res_banderas_d;

  logic es_aritmetica;
  assign es_aritmetica = (op_q == 3'b000) || (op_q == 3'b001);

  // Next-state, datapath capture and ALU drive; ALU inputs stay zero outside the two passes
  always_comb begin
    estado_d       = estado_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    ancho_d        = ancho_q;
    dato_bajo_d    = dato_bajo_q;
    flags_bajo_d   = flags_bajo_q;
    res_dato_d     = res_dato_q;
    res_banderas_d = res_banderas_q;
    alu_a          = 8'h00;
    alu_b          = 8'h00;
    alu_op         = 3'b000;
    alu_cin        = 1'b0;
    cmd_ready      = 1'b0;
    res_valid      = 1'b0;
    ocupado        = 1'b1;

    case (estado_q)
      IDLE: begin
        cmd_ready = 1'b1;
        ocupado   = 1'b0;
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          op_d     = cmd_op;
          ancho_d  = cmd_ancho;
          estado_d = BAJO;
        end
      end
      BAJO: begin
        alu_a        = a_q[7:0];
        alu_b        = b_q[7:0];
        alu_op       = op_q;
        alu_cin      = (op_q == 3'b001);
        dato_bajo_d  = alu_resultado;
        flags_bajo_d = alu_banderas;
        if (ancho_q) begin
          estado_d = ALTO;
        end else begin
          res_dato_d     = {8'h00, alu_resultado};
          res_banderas_d = alu_banderas;
          estado_d       = HECHO;
        end
      end
      ALTO: begin
        alu_a      = a_q[15:8];
        alu_b      = b_q[15:8];
        alu_op     = op_q;
        alu_cin    = es_aritmetica & flags_bajo_q[FC];
        res_dato_d = {alu_resultado, dato_bajo_q};
        // Zero only when both bytes are zero; sign, carry and overflow belong to the top byte
        res_banderas_d[FN] = alu_banderas[FN];
        res_banderas_d[FZ] = alu_banderas[FZ] & flags_bajo_q[FZ];
        res_banderas_d[FC] = alu_banderas[FC];
        res_banderas_d[FV] = alu_banderas[FV];
        estado_d = HECHO;
      end
      HECHO: begin
        res_valid = 1'b1;
        if (res_ready) begin
          estado_d = IDLE;
        end
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q       <= IDLE;
      a_q            <= 16'h0000;
      b_q            <= 16'h0000;
      op_q           <= 3'b000;
      ancho_q        <= 1'b0;
      dato_bajo_q    <= 8'h00;
      flags_bajo_q   <= 4'h0;
      res_dato_q     <= 16'h0000;
      res_banderas_q <= 4'h0;
    end else begin
      estado_q       <= estado_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      ancho_q        <= ancho_d;
      dato_bajo_q    <= dato_bajo_d;
      flags_bajo_q   <= flags_bajo_d;
      res_dato_q     <= res_dato_d;
      res_banderas_q <= res_banderas_d;
    end
  end

  assign res_dato     = res_dato_q;
  assign res_banderas = res_banderas_q;

endmodule
